// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the decode stage: opcodes, ALU op encoding,
// control bundle and the ID/EX register layout.
package decode_stage_pkg;

  localparam int unsigned INST_SIZE = 32;
  localparam logic [INST_SIZE-1:0] INST_SIZE_ZEROS = '0;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    pc_src;
    logic    reg_we;
    logic    mem_re;
    logic    mem_we;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  typedef struct packed {
    logic [INST_SIZE-1:0] pc;
    logic [INST_SIZE-1:0] rs1_val;
    logic [INST_SIZE-1:0] rs2_val;
    logic [INST_SIZE-1:0] imm;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           funct3;
    ctrl_t                ctrl;
  } idex_t;

  // alt selects SUB over ADD and SRA over SRL.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32x32 architectural register file: synchronous reset, one write port,
// two combinational read ports with write-through bypass. x0 reads as zero.
module decode_stage_register_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage update; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see a same-cycle writeback to the same register.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != '0) rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
    if (raddr_b != '0) rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, immediate generation, register file
// read, load-use hazard detection and the ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PC_DE,
  input  logic            FLUSH,
  input  logic            WB_EN,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            STALL_F,
  output logic [XLEN-1:0] PC_E,
  output logic [XLEN-1:0] RS1_VAL,
  output logic [XLEN-1:0] RS2_VAL,
  output logic [XLEN-1:0] IMM_E,
  output logic [4:0]      RD_E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [2:0]      FUNCT3_E,
  output logic [3:0]      ALU_OP_E,
  output logic            ALU_SRC_E,
  output logic            PC_SRC_E,
  output logic            REG_WE_E,
  output logic            MEM_RE_E,
  output logic            MEM_WE_E,
  output logic            BRANCH_E,
  output logic            JUMP_E,
  output logic            ILLEGAL_E
);

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            legal, uses_rs1, uses_rs2, stall_raw;
  ctrl_t           ctrl;
  idex_t           idex_d, idex_q;

  assign opcode = InstrD[6:0];
  assign rd     = InstrD[11:7];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];
  assign funct7 = InstrD[31:25];

  assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_u = {InstrD[31:12], 12'b0};
  assign imm_j = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  decode_stage_register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_register_file (
    .clk     (clk),
    .rst     (rst),
    .we      (WB_EN),
    .waddr   (WB_RD),
    .wdata   (WB_DATA),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rs1_val),
    .rdata_b (rs2_val)
  );

  // Opcode decode into control bundle, immediate and source-register usage.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = AluAdd;
    imm         = '0;
    legal       = 1'b1;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (opcode)
      OpLui: begin
        imm = imm_u; ctrl.alu_op = AluPassB; ctrl.alu_src = 1'b1; ctrl.reg_we = 1'b1;
      end
      OpAuipc: begin
        imm = imm_u; ctrl.pc_src = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_we = 1'b1;
      end
      OpJal: begin
        imm = imm_j; ctrl.jump = 1'b1; ctrl.pc_src = 1'b1; ctrl.reg_we = 1'b1;
      end
      OpJalr: begin
        imm = imm_i; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_we = 1'b1;
        uses_rs1 = 1'b1;
        legal    = (funct3 == 3'b000);
      end
      OpBranch: begin
        imm = imm_b; ctrl.branch = 1'b1; ctrl.alu_op = AluSub;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OpLoad: begin
        imm = imm_i; ctrl.mem_re = 1'b1; ctrl.reg_we = 1'b1; ctrl.alu_src = 1'b1;
        uses_rs1 = 1'b1;
        legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OpStore: begin
        imm = imm_s; ctrl.mem_we = 1'b1; ctrl.alu_src = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        legal    = (funct3 <= 3'b010);
      end
      OpImm: begin
        imm = imm_i; ctrl.alu_src = 1'b1; ctrl.reg_we = 1'b1;
        // Only the shift-right encoding lets funct7[5] alter the op; ADDI keeps its sign bit.
        ctrl.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        uses_rs1 = 1'b1;
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
      end
      OpReg: begin
        ctrl.reg_we = 1'b1;
        ctrl.alu_op = alu_from_funct3(funct3, funct7[5]);
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        legal    = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      end
      default: legal = 1'b0;
    endcase

    // The all-zero word is fetch's bubble, not a fault.
    if (InstrD == INST_SIZE_ZEROS) begin
      ctrl     = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end else if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      uses_rs1     = 1'b0;
      uses_rs2     = 1'b0;
    end
  end

  // Load-use hazard against the load currently in execute.
  always_comb begin
    stall_raw = idex_q.ctrl.mem_re && (idex_q.rd != 5'd0) &&
                ((uses_rs1 && (rs1 == idex_q.rd)) || (uses_rs2 && (rs2 == idex_q.rd)));
    STALL_F   = stall_raw && !FLUSH && !rst;
  end

  // Next ID/EX contents: bubble on flush or stall, decoded values otherwise.
  always_comb begin
    idex_d = '0;
    if (!FLUSH && !stall_raw) begin
      idex_d.pc      = PC_DE;
      idex_d.rs1_val = rs1_val;
      idex_d.rs2_val = rs2_val;
      idex_d.imm     = imm;
      idex_d.rd      = rd;
      idex_d.rs1     = rs1;
      idex_d.rs2     = rs2;
      idex_d.funct3  = funct3;
      idex_d.ctrl    = ctrl;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign PC_E      = idex_q.pc;
  assign RS1_VAL   = idex_q.rs1_val;
  assign RS2_VAL   = idex_q.rs2_val;
  assign IMM_E     = idex_q.imm;
  assign RD_E      = idex_q.rd;
  assign RS1_E     = idex_q.rs1;
  assign RS2_E     = idex_q.rs2;
  assign FUNCT3_E  = idex_q.funct3;
  assign ALU_OP_E  = idex_q.ctrl.alu_op;
  assign ALU_SRC_E = idex_q.ctrl.alu_src;
  assign PC_SRC_E  = idex_q.ctrl.pc_src;
  assign REG_WE_E  = idex_q.ctrl.reg_we;
  assign MEM_RE_E  = idex_q.ctrl.mem_re;
  assign MEM_WE_E  = idex_q.ctrl.mem_we;
  assign BRANCH_E  = idex_q.ctrl.branch;
  assign JUMP_E    = idex_q.ctrl.jump;
  assign ILLEGAL_E = idex_q.ctrl.illegal;

endmodule
